// File: rtl/exp_stream_pkg.sv
// Shared types and sizes for the exponentiator stream wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exp_stream_pkg;

    localparam int JOB_WORDS = 9;    // 4 words n, 1 word e, 4 words m
    localparam int RES_WORDS = 4;    // 128-bit result as 4 x 32-bit words
    localparam int WORD_W    = 32;
    localparam int OP_W      = 128;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Holds a 128-bit result and presents it as 4 x 32-bit words, LS word first.
// Latency: word 0 is visible in the cycle after i_load; one word per handshake.
// Backpressure: o_dat/o_last hold while i_rdy is low; the index moves only on i_en & i_rdy.
//
// Ports: clk/rst clock and async active-high reset; i_load/i_dat capture a new
// result; i_en marks the words as valid (drain phase); i_rdy consumer ready;
// o_dat current word; o_last high on word 3; o_done pulses on the final handshake.
module word_serializer
    import exp_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [OP_W-1:0]   i_dat,
    input  logic              i_en,
    input  logic              i_rdy,
    output logic [WORD_W-1:0] o_dat,
    output logic              o_last,
    output logic              o_done
);

    localparam logic [1:0] IDX_LAST = 2'(RES_WORDS - 1);

    logic [OP_W-1:0] r_dat;
    logic [1:0]      r_idx;
    logic            w_hs;
    logic            w_at_last;

    assign w_hs      = i_en & i_rdy;
    assign w_at_last = (r_idx == IDX_LAST);

    // The 2-bit index wraps 3 -> 0 on the final handshake, so the next job
    // always starts at word 0 without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat <= '0;
            r_idx <= '0;
        end else begin
            if (i_load) begin
                r_dat <= i_dat;
            end
            if (w_hs) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign o_dat  = r_dat[r_idx*WORD_W +: WORD_W];
    assign o_last = i_en & w_at_last;
    assign o_done = w_hs & w_at_last;

endmodule

// File: rtl/exp_stream_ctrl.sv
// Stream wrapper around the modular exponentiator: 9-word job in, 4-word result out.
// Latency: START_CYCLES start pulse, then exponentiator time, then 1 cycle to first result word.
// Backpressure: in_ready only in LOAD; result words hold while out_ready is low.
//
// Ports: clk/reset (async, active-high); in_valid/in_ready/in_data job stream;
// out_valid/out_ready/out_data/out_last/out_err result stream; exp_start/exp_m/
// exp_e/exp_n drive the exponentiator, exp_c/exp_ready come back from it;
// busy high outside LOAD; exp_cycles saturating RUN-phase length of the last job.
module exp_stream_ctrl
    import exp_stream_pkg::*;
#(
    parameter int START_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err,
    output logic              exp_start,
    output logic [OP_W-1:0]   exp_m,
    output logic [WORD_W-1:0] exp_e,
    output logic [OP_W-1:0]   exp_n,
    input  logic [OP_W-1:0]   exp_c,
    input  logic              exp_ready,
    output logic              busy,
    output logic [31:0]       exp_cycles
);

    localparam logic [3:0]  WIDX_LAST = 4'(JOB_WORDS - 1);
    localparam logic [31:0] SC_LAST   = 32'(START_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_widx;
    logic [OP_W-1:0]   r_n;
    logic [OP_W-1:0]   r_m;
    logic [WORD_W-1:0] r_e;
    logic              r_err;
    logic [31:0]       r_scnt;
    logic [31:0]       r_cnt;
    logic [31:0]       r_cycles;

    logic              w_load;
    logic              w_drain;
    logic              w_in_hs;
    logic              w_last_word;
    logic              w_run_done;
    logic              w_ser_load;
    logic [OP_W-1:0]   w_ser_dat;
    logic              w_ser_done;
    logic [1:0]        w_nidx;
    logic [1:0]        w_midx;

    assign w_load      = (r_state == LOAD);
    assign w_drain     = (r_state == DRAIN);
    assign w_in_hs     = in_valid & w_load;
    assign w_last_word = w_in_hs & (r_widx == WIDX_LAST);

    // r_cnt is cleared in START and never returns to zero once it has counted
    // (it saturates), so a nonzero count means "not the first RUN cycle". In
    // the first RUN cycle exp_ready still reflects the previous job.
    assign w_run_done  = (r_state == RUN) & (r_cnt != '0) & exp_ready;

    // Word slots: 0..3 -> n, 4 -> e, 5..8 -> m. For 5..8 the low two index
    // bits minus one give 0..3.
    assign w_nidx = r_widx[1:0];
    assign w_midx = r_widx[1:0] - 2'd1;

    // A rejected job (even n) drains an all-zero result.
    assign w_ser_load = w_run_done | (w_last_word & ~r_n[0]);
    assign w_ser_dat  = w_run_done ? exp_c : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_last_word) w_state_nxt = r_n[0] ? START : DRAIN;
            START:   if (r_scnt == SC_LAST) w_state_nxt = RUN;
            RUN:     if (w_run_done) w_state_nxt = DRAIN;
            DRAIN:   if (w_ser_done) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_widx   <= '0;
            r_n      <= '0;
            r_m      <= '0;
            r_e      <= '0;
            r_err    <= 1'b0;
            r_scnt   <= '0;
            r_cnt    <= '0;
            r_cycles <= '0;
        end else begin
            if (w_in_hs) begin
                r_widx <= (r_widx == WIDX_LAST) ? 4'd0 : r_widx + 4'd1;
                if (r_widx < 4'd4) begin
                    r_n[w_nidx*WORD_W +: WORD_W] <= in_data;
                end else if (r_widx == 4'd4) begin
                    r_e <= in_data;
                end else begin
                    r_m[w_midx*WORD_W +: WORD_W] <= in_data;
                end
            end

            if (w_last_word) begin
                r_err <= ~r_n[0];
            end

            r_scnt <= (r_state == START) ? r_scnt + 32'd1 : 32'd0;

            if (r_state == START) begin
                r_cnt <= '0;
            end else if ((r_state == RUN) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_run_done) begin
                r_cycles <= r_cnt;
            end
        end
    end

    word_serializer u_ser (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_ser_load),
        .i_dat  (w_ser_dat),
        .i_en   (w_drain),
        .i_rdy  (out_ready),
        .o_dat  (out_data),
        .o_last (out_last),
        .o_done (w_ser_done)
    );

    // in_ready is masked by the asynchronous reset so it reads 0 while reset
    // is held, yet is already 1 in the first cycle after release.
    assign in_ready   = w_load & ~reset;
    assign out_valid  = w_drain;
    assign out_err    = w_drain & r_err;
    assign busy       = ~w_load;
    assign exp_start  = (r_state == START);
    assign exp_n      = r_n;
    assign exp_e      = r_e;
    assign exp_m      = r_m;
    assign exp_cycles = r_cycles;

endmodule

// File: tb/tb_exp_stream_ctrl.sv
module tb_exp_stream_ctrl;

    localparam int S = 2;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic [31:0]  in_data   = '0;
    logic         out_ready = 1'b0;
    logic [127:0] exp_c     = 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D;
    logic         exp_ready = 1'b1;

    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_err;
    logic         exp_start;
    logic [127:0] exp_m;
    logic [31:0]  exp_e;
    logic [127:0] exp_n;
    logic         busy;
    logic [31:0]  exp_cycles;

    exp_stream_ctrl #(.START_CYCLES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_err    (out_err),
        .exp_start  (exp_start),
        .exp_m      (exp_m),
        .exp_e      (exp_e),
        .exp_n      (exp_n),
        .exp_c      (exp_c),
        .exp_ready  (exp_ready),
        .busy       (busy),
        .exp_cycles (exp_cycles)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Plain square-and-multiply reference for m^e mod n.
    function automatic logic [127:0] modexp(input logic [127:0] b, input logic [31:0] e,
                                            input logic [127:0] n);
        logic [255:0] r;
        logic [255:0] x;
        r = 256'(1) % 256'(n);
        x = 256'(b) % 256'(n);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % 256'(n);
            x = (x * x) % 256'(n);
        end
        return r[127:0];
    endfunction

    // Behavioural exponentiator: restarts while exp_start is high; after start
    // drops it spends f_lat extra cycles with ready low, then raises ready with
    // the result and keeps it high (stale) until the next start.
    int unsigned f_lat  = 0;
    int unsigned f_left = 0;
    bit          f_run  = 1'b0;

    always @(posedge clk) begin
        if (exp_start) begin
            f_run  <= 1'b1;
            f_left <= f_lat;
        end else if (f_run) begin
            if (f_left == 0) begin
                exp_ready <= 1'b1;
                exp_c     <= modexp(exp_m, exp_e, exp_n);
                f_run     <= 1'b0;
            end else begin
                exp_ready <= 1'b0;
                f_left    <= f_left - 1;
            end
        end
    end

    // Per-cycle watch while a job is in flight: operands must match the job
    // that was sent and no input may be accepted.
    bit           mon_en    = 1'b0;
    int unsigned  mon_bad   = 0;
    int unsigned  mon_start = 0;
    int unsigned  snap_bad;
    int unsigned  snap_start;
    logic [127:0] job_n;
    logic [127:0] job_m;
    logic [31:0]  job_e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_n !== job_n || exp_e !== job_e || exp_m !== job_m || in_ready !== 1'b0)
                mon_bad <= mon_bad + 1;
            if (exp_start === 1'b1)
                mon_start <= mon_start + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input bit gaps);
        int t;
        bit rdy;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        do begin
            rdy = in_ready;
            tick();
            t++;
        end while (!rdy && t < 50);
        in_valid = 1'b0;
        chk_val("in_word_accepted", 128'(rdy), 128'd1);
    endtask

    task automatic load_job(input logic [127:0] n, input logic [31:0] e, input logic [127:0] m,
                            input int lat, input bit gaps);
        logic [31:0] w [9];
        job_n = n;
        job_e = e;
        job_m = m;
        f_lat = lat;
        for (int i = 0; i < 4; i++) begin
            w[i]     = n[i*32 +: 32];
            w[5 + i] = m[i*32 +: 32];
        end
        w[4] = e;
        for (int i = 0; i < 9; i++) send_word(w[i], gaps);
        snap_bad   = mon_bad;
        snap_start = mon_start;
        mon_en     = 1'b1;
    endtask

    // Latency counts cycles after the word-8 handshake edge (the first sample
    // after that edge is cycle 1). A good job spends S START cycles, then the
    // exponentiator raises ready at the end of RUN cycle lat, so completion is
    // RUN cycle lat+1 (that is exp_cycles) and DRAIN starts at S+lat+3.
    task automatic finish_job(input logic [127:0] n, input logic [31:0] e, input logic [127:0] m,
                              input int lat, input bit stall);
        logic [127:0] c;
        bit           err;
        int           cyc;
        int           nw;
        err = ~n[0];
        c   = err ? 128'd0 : modexp(m, e, n);
        // Offer junk input throughout the job; none of it may be taken.
        in_valid = 1'b1;
        in_data  = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk_val("first_valid_latency", 128'(cyc), err ? 128'd1 : 128'(S + lat + 3));
        chk_val("start_pulse_cycles", 128'(mon_start - snap_start), err ? 128'd0 : 128'(S));
        chk_val("busy_in_drain", 128'(busy), 128'd1);
        if (!err) chk_val("exp_cycles", 128'(exp_cycles), 128'(lat + 1));
        for (int k = 0; k < 4; k++) begin
            nw = (stall && k == 2) ? 3 : int'($urandom_range(0, 1));
            for (int j = 0; j < nw; j++) begin
                out_ready = 1'b0;
                tick();
                if (stall && k == 2) begin
                    chk_val("hold_out_data", 128'(out_data), 128'(c[k*32 +: 32]));
                    chk_val("hold_out_last", 128'(out_last), 128'd0);
                    chk_val("hold_out_err", 128'(out_err), 128'(err));
                end
            end
            chk_val($sformatf("out_valid[%0d]", k), 128'(out_valid), 128'd1);
            chk_val($sformatf("out_data[%0d]", k), 128'(out_data), 128'(c[k*32 +: 32]));
            chk_val($sformatf("out_last[%0d]", k), 128'(out_last), 128'(k == 3));
            chk_val($sformatf("out_err[%0d]", k), 128'(out_err), 128'(err));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        mon_en = 1'b0;
        chk_val("operands_stable_no_input", 128'(mon_bad - snap_bad), 128'd0);
        chk_val("in_ready_after_last", 128'(in_ready), 128'd1);
        chk_val("out_valid_after_last", 128'(out_valid), 128'd0);
        chk_val("busy_after_last", 128'(busy), 128'd0);
    endtask

    task automatic run_job(input logic [127:0] n, input logic [31:0] e, input logic [127:0] m,
                           input int lat, input bit gaps, input bit stall);
        load_job(n, e, m, lat, gaps);
        finish_job(n, e, m, lat, stall);
    endtask

    task automatic check_reset_vals(input string tag);
        chk_val({tag, "_in_ready"}, 128'(in_ready), 128'd0);
        chk_val({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk_val({tag, "_out_data"}, 128'(out_data), 128'd0);
        chk_val({tag, "_out_last"}, 128'(out_last), 128'd0);
        chk_val({tag, "_out_err"}, 128'(out_err), 128'd0);
        chk_val({tag, "_exp_start"}, 128'(exp_start), 128'd0);
        chk_val({tag, "_exp_n"}, exp_n, 128'd0);
        chk_val({tag, "_exp_e"}, 128'(exp_e), 128'd0);
        chk_val({tag, "_exp_m"}, exp_m, 128'd0);
        chk_val({tag, "_busy"}, 128'(busy), 128'd0);
        chk_val({tag, "_exp_cycles"}, 128'(exp_cycles), 128'd0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] rn;
        logic [127:0] rm;
        logic [31:0]  re;

        // Power-up reset.
        reset = 1'b1;
        repeat (3) tick();
        check_reset_vals("rst0");
        reset = 1'b0;
        tick();
        chk_val("in_ready_after_release", 128'(in_ready), 128'd1);

        // Known operands: 4^13 mod 497, 4^0 mod 497, even modulus.
        run_job(128'd497, 32'd13, 128'd4, 3, 1'b0, 1'b0);
        run_job(128'd497, 32'd0, 128'd4, 0, 1'b0, 1'b0);
        run_job(128'd10, 32'd7, 128'd3, 0, 1'b0, 1'b0);

        // Wide random operands with input gaps and a 3-cycle stall on word 2.
        rn = rand128();
        rn[0] = 1'b1;
        run_job(rn, $urandom, rand128(), int'($urandom_range(0, 6)), 1'b1, 1'b1);

        // Reset in the middle of RUN, then a fresh job.
        rn = rand128();
        rn[0] = 1'b1;
        load_job(rn, $urandom, rand128(), 40, 1'b1);
        repeat (S + 3) tick();
        chk_val("midrun_busy", 128'(busy), 128'd1);
        chk_val("midrun_no_valid", 128'(out_valid), 128'd0);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        check_reset_vals("rst_midrun");
        reset = 1'b0;
        tick();
        chk_val("in_ready_after_midrun_reset", 128'(in_ready), 128'd1);
        run_job(128'd497, 32'd3, 128'd2, 2, 1'b1, 1'b0);

        // Back-to-back: the first job leaves exp_ready high with its result.
        run_job(128'd497, 32'd5, 128'd7, 0, 1'b0, 1'b0);
        run_job(128'd497, 32'd11, 128'd9, 4, 1'b0, 1'b0);

        // Random mix, roughly one job in four rejected.
        for (int j = 0; j < 12; j++) begin
            rn = rand128();
            rn[0] = ($urandom_range(0, 3) != 0);
            rm = rand128();
            re = $urandom;
            run_job(rn, re, rm, int'($urandom_range(0, 8)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
